// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf
//   EX/MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer
//   and a synchronous flush. The payload and control field are opaque and
//   their widths are set by parameters. While no valid entry is presented,
//   out_ctrl is driven to CTRL_BUBBLE, so a bubble can never write memory or
//   the register file.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous kill of every held entry
//   in_valid   EX presents an instruction
//   in_ready   stage can accept (registered, = ~s_valid)
//   in_data    payload from EX   [DATA_W]
//   in_ctrl    control from EX   [CTRL_W]
//   out_valid  main entry valid
//   out_ready  MEM accepts (0 = stall)
//   out_data   payload to MEM    [DATA_W]
//   out_ctrl   control to MEM    [CTRL_W], CTRL_BUBBLE when out_valid=0
//
// State is implied by the two valid bits:
//   state | meaning
//   EMPTY | m_valid=0 s_valid=0, nothing held
//   ONE   | m_valid=1 s_valid=0, main drives outputs, skid free
//   TWO   | m_valid=1 s_valid=1, skid holds the overflow beat, in_ready=0
//   (m_valid=0 s_valid=1 is unreachable)

module ex_mem_stage_buf #(
  parameter int unsigned              DATA_W      = 69,
  parameter int unsigned              CTRL_W      = 4,
  parameter logic [CTRL_W-1:0]        CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl;

  logic              m_valid_d, s_valid_d;
  logic [DATA_W-1:0] m_data_d,  s_data_d;
  logic [CTRL_W-1:0] m_ctrl_d,  s_ctrl_d;

  logic in_fire, out_fire;

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally; the skid entry absorbs the beat accepted meanwhile.
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    m_valid_d = m_valid;
    m_data_d  = m_data;
    m_ctrl_d  = m_ctrl;
    s_valid_d = s_valid;
    s_data_d  = s_data;
    s_ctrl_d  = s_ctrl;

    if (flush) begin
      // Data is kept; only the valids and control are killed. A coincident
      // out_fire has already been sampled by MEM, so nothing else to do.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = CTRL_BUBBLE;
      s_ctrl_d  = CTRL_BUBBLE;
    end else begin
      case ({m_valid, s_valid})
        2'b00: begin
          if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
          end
        end
        2'b10: begin
          if (out_fire && in_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            m_valid_d = 1'b0;
          end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl;
          end
        end
        2'b11: begin
          if (out_fire) begin
            m_data_d  = s_data;
            m_ctrl_d  = s_ctrl;
            s_valid_d = 1'b0;
          end
        end
        default: begin
          // Unreachable; drop to EMPTY rather than expose an orphaned skid beat.
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
          m_ctrl_d  = CTRL_BUBBLE;
          s_ctrl_d  = CTRL_BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_ctrl  <= CTRL_BUBBLE;
      s_ctrl  <= CTRL_BUBBLE;
    end else begin
      m_valid <= m_valid_d;
      s_valid <= s_valid_d;
      m_data  <= m_data_d;
      s_data  <= s_data_d;
      m_ctrl  <= m_ctrl_d;
      s_ctrl  <= s_ctrl_d;
    end
  end

endmodule
